// File: rtl/odd_parity_serial_tx.sv
// ---------------------------------------------------------------------------
// odd_parity_serial_tx
//
// Purpose
//   Serialises a DATA_W-bit payload and its externally computed odd-parity bit
//   into an asynchronous frame: start(0), D0..D(DATA_W-1) LSB first, parity,
//   stop(1). Each serial bit is held for CLKS_PER_BIT clock cycles. The parity
//   bit is sent exactly as supplied; it is never recomputed here.
//
// Ports
//   clk          in   1       single clock, all state changes on posedge
//   rst          in   1       synchronous, active-high reset
//   data_in      in   DATA_W  payload, sampled on accept
//   parity_in    in   1       odd-parity bit for data_in, sampled on accept
//   valid_in     in   1       upstream has a byte to send
//   ready_out    out  1       block can accept a byte (high only in IDLE)
//   tx           out  1       serial line, idle high, registered
//   busy         out  1       a frame is in progress (state != IDLE)
//   done         out  1       one-cycle pulse on the last cycle of the stop bit
//   dbg_state_o  out  3       current FSM state, for observation only
//
// Handshake
//   A byte is accepted on a rising clk edge where valid_in && ready_out.
//   ready_out depends only on registered state, never on valid_in. valid_in
//   while ready_out is low is ignored and nothing is latched, so upstream must
//   hold valid_in and its data until the accepting edge.
// ---------------------------------------------------------------------------
module odd_parity_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state_o
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q,  baud_d;
    logic [BIT_W-1:0]    bit_q,   bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q,   par_d;
    logic                tx_q,    tx_d;
    logic                done_q,  done_d;

    logic                bit_end;
    logic                accept;

    assign ready_out   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign accept      = valid_in && ready_out;
    assign bit_end     = (baud_q == BAUD_LAST);
    assign tx          = tx_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        // Baud counter idles at 0 and wraps at every bit boundary.
        if (state_q == S_IDLE || bit_end) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d = data_in;
                    par_d   = parity_in;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // done is registered, so it is raised one cycle early to
                // coincide with the last cycle of the stop bit.
                if (baud_q == BAUD_PRE) begin
                    done_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // tx is registered from the next state so the line level changes on
        // the same edge as the state, with no input-to-tx combinational path.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule
